cgia_bus_arbiter: RTL and testbench
===================================

// Module: cgia_bus_arbiter
// PURPOSE
//  Shares the single Wishbone (classic) memory port between the CGIA video fetcher (master V) and the CPU (master C).
//  Sits between fetcher/CPU and the memory slave. V normally wins; a fairness flag stops the CPU being starved.
//  A bus watchdog ends any cycle the slave fails to acknowledge.
// PARAMETERS
//  AW        24  address width, both masters and slave
//  DW        16  data width; SW = DW/8 byte selects
//  TIMEOUT   15  cycles with stb high and no ack before watchdog fires (1..255)
// PORTS
//  clk_i      in   1   SYSCON clock
//  reset_i    in   1   SYSCON reset, synchronous, active-high
//  v_cyc_i    in   1   V cycle request; v_stb_i, v_we_i in 1; v_adr_i in AW; v_dat_i in DW; v_sel_i in SW
//  v_urgent_i in   1   V line buffer below watermark; overrides fairness
//  v_ack_o    out  1   ack to V; v_err_o out 1 watchdog error; v_dat_o out DW read data
//  c_cyc_i    in   1   C cycle request; c_stb_i, c_we_i in 1; c_adr_i in AW; c_dat_i in DW; c_sel_i in SW
//  c_ack_o    out  1   ack to C; c_err_o out 1 watchdog error; c_dat_o out DW read data
//  s_cyc_o    out  1   slave cycle; s_stb_o, s_we_o out 1; s_adr_o out AW; s_dat_o out DW; s_sel_o out SW
//  s_ack_i    in   1   slave ack; s_dat_i in DW read data
//  gnt_o      out  2   current owner, one-hot {C,V}; 2'b00 = idle
// BEHAVIOUR
//  Reset: state IDLE, gnt_o=00, fair flag=0, watchdog=0; all s_* and master ack/err outputs 0 in the cycle after reset.
//  States: IDLE, OWN_V, OWN_C. Grant is registered: request seen at edge N, owner's signals on slave from N+1.
//  IDLE: V only -> OWN_V; C only -> OWN_C; both -> OWN_V if v_urgent_i or fair=0, else OWN_C.
//  OWN_x: slave signals = owner's signals, s_cyc_o = x_cyc_i; other master's ack/err held 0.
//  OWN_x -> IDLE on the edge where owner's cyc is low (no combinational re-grant; one idle cycle between owners).
//  Fair flag: set when an OWN_V tenure ends with c_cyc_i high; cleared on entry to OWN_C.
//  Ownership is never pre-empted mid-cycle; V burst (cyc held over many stb/ack) keeps the bus.
//  x_ack_o = s_ack_i & owner==x & x_stb_i (combinational); x_dat_o = s_dat_i for both (qualified by ack).
//  Watchdog: 8-bit count; clears on s_ack_i, on stb low or in IDLE; increments while s_stb_o & ~s_ack_i.
//  When count reaches TIMEOUT: x_err_o pulses 1 cycle to owner, s_stb_o forced 0 that cycle, count clears;
//  arbiter then waits for owner to drop cyc (normal release). Err and ack never high together.
//  Owner dropping cyc while stb high with ack pending: release honoured; late s_ack_i is discarded.
//  Reset mid-cycle: all outputs to 0 at next edge regardless of state; no ack delivered.
// TESTING
//  V only, 4-word burst, slave acks each stb next cycle -> gnt_o=01 one cycle after v_cyc_i, 4 v_ack_o, c_ack_o=0.
//  V and C request same cycle, fair=0, v_urgent_i=0 -> OWN_V; V drops cyc -> 1 idle cycle -> gnt_o=10.
//  V re-requests immediately after tenure with C waiting, fair=1 -> C granted; with v_urgent_i=1 -> V granted.
//  C single read, slave never acks, TIMEOUT=15 -> c_err_o pulses exactly 15 cycles after stb, c_ack_o stays 0.
//  Ack at count 14 -> no err; count restarts; err only after a further 15 unacked cycles.
//  reset_i asserted during OWN_C with stb high -> next edge gnt_o=00, s_cyc_o=0, fair=0, no ack/err.

Source files
------------

// File: rtl/cgia_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cgia_bus_arbiter
//
// Shares one Wishbone classic memory port between the CGIA video fetcher
// (master V) and the CPU (master C). V normally wins a simultaneous request.
// A fairness flag hands the bus to C after a V tenure that kept C waiting,
// unless V reports an urgent line-buffer condition. A bus watchdog ends any
// strobe the slave leaves unacknowledged for TIMEOUT cycles.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   v_*_i / v_*_o             Wishbone master V (request side + ack/err/data)
//   v_urgent_i                V line buffer below watermark, overrides fairness
//   c_*_i / c_*_o             Wishbone master C (request side + ack/err/data)
//   s_*_o / s_ack_i, s_dat_i  Wishbone slave port
//   gnt_o                     current owner one-hot {C,V}, 2'b00 when idle
// -----------------------------------------------------------------------------
module cgia_bus_arbiter #(
    parameter int AW      = 24,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                clk_i,
    input  logic                reset_i,
    // master V (video fetcher)
    input  logic                v_cyc_i,
    input  logic                v_stb_i,
    input  logic                v_we_i,
    input  logic [AW-1:0]       v_adr_i,
    input  logic [DW-1:0]       v_dat_i,
    input  logic [DW/8-1:0]     v_sel_i,
    input  logic                v_urgent_i,
    output logic                v_ack_o,
    output logic                v_err_o,
    output logic [DW-1:0]       v_dat_o,
    // master C (CPU)
    input  logic                c_cyc_i,
    input  logic                c_stb_i,
    input  logic                c_we_i,
    input  logic [AW-1:0]       c_adr_i,
    input  logic [DW-1:0]       c_dat_i,
    input  logic [DW/8-1:0]     c_sel_i,
    output logic                c_ack_o,
    output logic                c_err_o,
    output logic [DW-1:0]       c_dat_o,
    // slave
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_adr_o,
    output logic [DW-1:0]       s_dat_o,
    output logic [DW/8-1:0]     s_sel_o,
    input  logic                s_ack_i,
    input  logic [DW-1:0]       s_dat_i,
    // owner
    output logic [1:0]          gnt_o
);

    localparam int SW = DW / 8;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    // State codes double as the one-hot grant vector {C,V}.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN_V = 2'b01,
        ST_OWN_C = 2'b10
    } state_e;

    state_e     state_q, state_d;
    logic       fair_q, fair_d;
    logic [7:0] wdog_q, wdog_d;

    logic       own_v_s;
    logic       own_c_s;
    logic       owner_stb_s;
    logic       wdog_fire_s;

    // Ownership decode from the registered state.
    always_comb begin
        own_v_s = (state_q == ST_OWN_V);
        own_c_s = (state_q == ST_OWN_C);
    end

    // Watchdog expiry: the strobe has been outstanding TIMEOUT cycles.
    always_comb begin
        if ((state_q != ST_IDLE) && (wdog_q == TIMEOUT_C)) begin
            wdog_fire_s = 1'b1;
        end else begin
            wdog_fire_s = 1'b0;
        end
    end

    // Slave-side multiplexer: owner's signals pass through, zeros when idle.
    // The strobe is withheld in the cycle the watchdog fires.
    always_comb begin
        s_cyc_o     = 1'b0;
        owner_stb_s = 1'b0;
        s_we_o      = 1'b0;
        s_adr_o     = {AW{1'b0}};
        s_dat_o     = {DW{1'b0}};
        s_sel_o     = {SW{1'b0}};
        case (state_q)
            ST_OWN_V: begin
                s_cyc_o     = v_cyc_i;
                owner_stb_s = v_stb_i;
                s_we_o      = v_we_i;
                s_adr_o     = v_adr_i;
                s_dat_o     = v_dat_i;
                s_sel_o     = v_sel_i;
            end
            ST_OWN_C: begin
                s_cyc_o     = c_cyc_i;
                owner_stb_s = c_stb_i;
                s_we_o      = c_we_i;
                s_adr_o     = c_adr_i;
                s_dat_o     = c_dat_i;
                s_sel_o     = c_sel_i;
            end
            default: begin
                s_cyc_o     = 1'b0;
                owner_stb_s = 1'b0;
            end
        endcase
        s_stb_o = owner_stb_s & ~wdog_fire_s;
    end

    // Master-side responses. Ack is suppressed when the watchdog fires so
    // that ack and err are never seen together; read data is broadcast.
    always_comb begin
        v_ack_o = s_ack_i & own_v_s & v_stb_i & ~wdog_fire_s;
        c_ack_o = s_ack_i & own_c_s & c_stb_i & ~wdog_fire_s;
        v_err_o = own_v_s & wdog_fire_s;
        c_err_o = own_c_s & wdog_fire_s;
        v_dat_o = s_dat_i;
        c_dat_o = s_dat_i;
    end

    // Watchdog next value: counts unacknowledged strobe cycles of the owner.
    always_comb begin
        if ((state_q == ST_IDLE) || !s_stb_o || s_ack_i) begin
            wdog_d = 8'd0;
        end else begin
            wdog_d = wdog_q + 8'd1;
        end
    end

    // Arbitration next state and fairness bookkeeping. An owner keeps the
    // bus until it drops cyc; the release edge always lands in IDLE, so two
    // tenures are separated by one idle cycle.
    always_comb begin
        state_d = state_q;
        fair_d  = fair_q;
        case (state_q)
            ST_IDLE: begin
                if (v_cyc_i && c_cyc_i) begin
                    if (v_urgent_i || !fair_q) begin
                        state_d = ST_OWN_V;
                    end else begin
                        state_d = ST_OWN_C;
                        fair_d  = 1'b0;
                    end
                end else if (v_cyc_i) begin
                    state_d = ST_OWN_V;
                end else if (c_cyc_i) begin
                    state_d = ST_OWN_C;
                    fair_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN_V: begin
                if (!v_cyc_i) begin
                    state_d = ST_IDLE;
                    // C sat through this tenure: it gets the next contest.
                    if (c_cyc_i) begin
                        fair_d = 1'b1;
                    end else begin
                        fair_d = fair_q;
                    end
                end else begin
                    state_d = ST_OWN_V;
                end
            end
            ST_OWN_C: begin
                if (!c_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OWN_C;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fair_d  = 1'b0;
            end
        endcase
    end

    // State, fairness flag and watchdog registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            fair_q  <= 1'b0;
            wdog_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            fair_q  <= fair_d;
            wdog_q  <= wdog_d;
        end
    end

    // Grant is the registered state itself.
    assign gnt_o = state_q;

endmodule

// File: tb/tb_cgia_bus_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for cgia_bus_arbiter: a directed vector table, hand-written
// watchdog / reset sequences, then randomized traffic against a
// transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_cgia_bus_arbiter;

    localparam int AW      = 24;
    localparam int DW      = 16;
    localparam int SW      = DW / 8;
    localparam int TIMEOUT = 15;

    localparam logic [AW-1:0] V_ADR = 24'hA5A5A5;
    localparam logic [AW-1:0] C_ADR = 24'h5A5A5A;
    localparam logic [DW-1:0] V_DAT = 16'h1234;
    localparam logic [DW-1:0] C_DAT = 16'hBEEF;
    localparam logic [SW-1:0] V_SEL = 2'b01;
    localparam logic [SW-1:0] C_SEL = 2'b10;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          reset_i;
    logic          v_cyc_i, v_stb_i, v_we_i, v_urgent_i;
    logic [AW-1:0] v_adr_i;
    logic [DW-1:0] v_dat_i;
    logic [SW-1:0] v_sel_i;
    logic          v_ack_o, v_err_o;
    logic [DW-1:0] v_dat_o;
    logic          c_cyc_i, c_stb_i, c_we_i;
    logic [AW-1:0] c_adr_i;
    logic [DW-1:0] c_dat_i;
    logic [SW-1:0] c_sel_i;
    logic          c_ack_o, c_err_o;
    logic [DW-1:0] c_dat_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [SW-1:0] s_sel_o;
    logic          s_ack_i;
    logic [DW-1:0] s_dat_i;
    logic [1:0]    gnt_o;

    int checks = 0;
    int errors = 0;

    cgia_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .v_cyc_i(v_cyc_i), .v_stb_i(v_stb_i), .v_we_i(v_we_i), .v_adr_i(v_adr_i),
        .v_dat_i(v_dat_i), .v_sel_i(v_sel_i), .v_urgent_i(v_urgent_i),
        .v_ack_o(v_ack_o), .v_err_o(v_err_o), .v_dat_o(v_dat_o),
        .c_cyc_i(c_cyc_i), .c_stb_i(c_stb_i), .c_we_i(c_we_i), .c_adr_i(c_adr_i),
        .c_dat_i(c_dat_i), .c_sel_i(c_sel_i),
        .c_ack_o(c_ack_o), .c_err_o(c_err_o), .c_dat_o(c_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .gnt_o(gnt_o)
    );

    typedef struct {
        logic       rst, vc, vs, vu, cc, cs, ack;
        logic [1:0] gnt;
        logic       scyc, sstb, vack, cack;
    } vec_t;

    vec_t tbl[$];

    // in = {rst, v_cyc, v_stb, v_urgent, c_cyc, c_stb, s_ack}
    // out = {gnt[1:0], s_cyc, s_stb, v_ack, c_ack}
    function automatic vec_t mk(input logic [6:0] in, input logic [5:0] out);
        vec_t v;
        v.rst = in[6]; v.vc = in[5]; v.vs = in[4]; v.vu = in[3];
        v.cc = in[2]; v.cs = in[1]; v.ack = in[0];
        v.gnt = out[5:4]; v.scyc = out[3]; v.sstb = out[2];
        v.vack = out[1]; v.cack = out[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_ctl(input logic rst, input logic vc, input logic vs, input logic vu,
                           input logic cc, input logic cs, input logic ack);
        reset_i = rst; v_cyc_i = vc; v_stb_i = vs; v_urgent_i = vu;
        c_cyc_i = cc; c_stb_i = cs; s_ack_i = ack;
    endtask

    // ---------------- reference model (tenure level) ----------------
    int m_own;      // 0 nobody, 1 V, 2 C
    bit m_fair;     // C is owed the next contested grant
    int m_unacked;  // consecutive strobe cycles without an ack in this tenure

    task automatic model_compare(input int cyc);
        logic [1:0]    e_gnt;
        logic          e_cyc, e_stb, e_we, e_vack, e_verr, e_cack, e_cerr;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        bit            fire;
        fire = (m_own != 0) && (m_unacked == TIMEOUT);
        e_gnt = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0;
        e_vack = 1'b0; e_verr = 1'b0; e_cack = 1'b0; e_cerr = 1'b0;
        if (m_own == 1) begin
            e_cyc = v_cyc_i; e_stb = v_stb_i && !fire; e_we = v_we_i;
            e_adr = v_adr_i; e_dat = v_dat_i; e_sel = v_sel_i;
            e_vack = s_ack_i && v_stb_i && !fire; e_verr = fire;
        end else if (m_own == 2) begin
            e_cyc = c_cyc_i; e_stb = c_stb_i && !fire; e_we = c_we_i;
            e_adr = c_adr_i; e_dat = c_dat_i; e_sel = c_sel_i;
            e_cack = s_ack_i && c_stb_i && !fire; e_cerr = fire;
        end
        check($sformatf("rand_cyc%0d", cyc),
              128'({gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
                    v_ack_o, v_err_o, c_ack_o, c_err_o, v_dat_o, c_dat_o}),
              128'({e_gnt, e_cyc, e_stb, e_we, e_adr, e_dat, e_sel,
                    e_vack, e_verr, e_cack, e_cerr, s_dat_i, s_dat_i}));
    endtask

    task automatic model_edge();
        bit fire, strobing;
        if (reset_i) begin
            m_own = 0; m_fair = 1'b0; m_unacked = 0;
        end else begin
            fire = (m_own != 0) && (m_unacked == TIMEOUT);
            strobing = ((m_own == 1) ? v_stb_i : (m_own == 2) ? c_stb_i : 1'b0) && !fire;
            if (strobing && !s_ack_i) m_unacked = m_unacked + 1;
            else m_unacked = 0;
            if (m_own == 0) begin
                if (v_cyc_i && c_cyc_i) m_own = (v_urgent_i || !m_fair) ? 1 : 2;
                else if (v_cyc_i) m_own = 1;
                else if (c_cyc_i) m_own = 2;
                if (m_own == 2) m_fair = 1'b0;
            end else if (m_own == 1) begin
                if (!v_cyc_i) begin
                    m_own = 0;
                    if (c_cyc_i) m_fair = 1'b1;
                end
            end else begin
                if (!c_cyc_i) m_own = 0;
            end
        end
    endtask

    task automatic run_random(input int n);
        bit quiet;
        quiet = 1'b0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 23) == 0) v_cyc_i = ~v_cyc_i;
            if ($urandom_range(0, 23) == 0) c_cyc_i = ~c_cyc_i;
            v_stb_i = v_cyc_i && ($urandom_range(0, 15) != 0);
            c_stb_i = c_cyc_i && ($urandom_range(0, 15) != 0);
            v_urgent_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) quiet = ~quiet;
            s_ack_i = !quiet && ($urandom_range(0, 2) == 0);
            reset_i = ($urandom_range(0, 299) == 0);
            v_we_i = 1'($urandom); c_we_i = 1'($urandom);
            v_adr_i = AW'($urandom); c_adr_i = AW'($urandom);
            v_dat_i = DW'($urandom); c_dat_i = DW'($urandom); s_dat_i = DW'($urandom);
            v_sel_i = SW'($urandom); c_sel_i = SW'($urandom);
            @(negedge clk_i);
            model_compare(i);
            @(posedge clk_i);
            model_edge();
            #1;
        end
    endtask

    initial begin
        logic [AW-1:0] e_adr;
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        v_we_i = 1'b1; v_adr_i = V_ADR; v_dat_i = V_DAT; v_sel_i = V_SEL;
        c_we_i = 1'b0; c_adr_i = C_ADR; c_dat_i = C_DAT; c_sel_i = C_SEL;
        s_dat_i = 16'hC0DE;
        repeat (2) @(posedge clk_i);
        #1;

        // V burst, V-then-C with idle gap, fairness, urgent override
        tbl.push_back(mk(7'b0_000_00_0, 6'b00_00_00));
        tbl.push_back(mk(7'b0_110_00_0, 6'b00_00_00));
        tbl.push_back(mk(7'b0_110_00_0, 6'b01_11_00));
        tbl.push_back(mk(7'b0_110_00_1, 6'b01_11_10));
        tbl.push_back(mk(7'b0_110_00_0, 6'b01_11_00));
        tbl.push_back(mk(7'b0_110_00_1, 6'b01_11_10));
        tbl.push_back(mk(7'b0_110_00_0, 6'b01_11_00));
        tbl.push_back(mk(7'b0_110_00_1, 6'b01_11_10));
        tbl.push_back(mk(7'b0_110_00_0, 6'b01_11_00));
        tbl.push_back(mk(7'b0_110_00_1, 6'b01_11_10));
        tbl.push_back(mk(7'b0_000_00_0, 6'b01_00_00));
        tbl.push_back(mk(7'b0_000_00_0, 6'b00_00_00));
        tbl.push_back(mk(7'b0_110_11_0, 6'b00_00_00));
        tbl.push_back(mk(7'b0_110_11_1, 6'b01_11_10));
        tbl.push_back(mk(7'b0_000_11_0, 6'b01_00_00));
        tbl.push_back(mk(7'b0_000_11_0, 6'b00_00_00));
        tbl.push_back(mk(7'b0_000_11_1, 6'b10_11_01));
        tbl.push_back(mk(7'b0_000_00_0, 6'b10_00_00));
        tbl.push_back(mk(7'b0_110_11_0, 6'b00_00_00));
        tbl.push_back(mk(7'b0_110_11_1, 6'b01_11_10));
        tbl.push_back(mk(7'b0_000_11_0, 6'b01_00_00));
        tbl.push_back(mk(7'b0_110_11_0, 6'b00_00_00));
        tbl.push_back(mk(7'b0_110_11_1, 6'b10_11_01));
        tbl.push_back(mk(7'b0_110_00_0, 6'b10_00_00));
        tbl.push_back(mk(7'b0_110_00_0, 6'b00_00_00));
        tbl.push_back(mk(7'b0_110_11_1, 6'b01_11_10));
        tbl.push_back(mk(7'b0_000_11_0, 6'b01_00_00));
        tbl.push_back(mk(7'b0_111_11_0, 6'b00_00_00));
        tbl.push_back(mk(7'b0_111_11_1, 6'b01_11_10));
        tbl.push_back(mk(7'b0_000_00_0, 6'b01_00_00));
        tbl.push_back(mk(7'b0_000_00_0, 6'b00_00_00));

        foreach (tbl[i]) begin
            set_ctl(tbl[i].rst, tbl[i].vc, tbl[i].vs, tbl[i].vu, tbl[i].cc, tbl[i].cs, tbl[i].ack);
            @(negedge clk_i);
            e_adr = (tbl[i].gnt == 2'b01) ? V_ADR : (tbl[i].gnt == 2'b10) ? C_ADR : '0;
            check($sformatf("tbl%0d_gnt", i), 128'(gnt_o), 128'(tbl[i].gnt));
            check($sformatf("tbl%0d_bus", i),
                  128'({s_cyc_o, s_stb_o, v_ack_o, c_ack_o, v_err_o, c_err_o}),
                  128'({tbl[i].scyc, tbl[i].sstb, tbl[i].vack, tbl[i].cack, 2'b00}));
            check($sformatf("tbl%0d_adr", i), 128'(s_adr_o), 128'(e_adr));
            check($sformatf("tbl%0d_rdat", i), 128'({v_dat_o, c_dat_o}), 128'({16'hC0DE, 16'hC0DE}));
            tick();
        end

        // C read the slave never acks: err exactly TIMEOUT cycles after stb
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        for (int k = 0; k <= TIMEOUT; k++) begin
            @(negedge clk_i);
            check($sformatf("to_k%0d_gnt", k), 128'(gnt_o), 128'(2'b10));
            check($sformatf("to_k%0d_err", k), 128'(c_err_o), 128'(k == TIMEOUT));
            check($sformatf("to_k%0d_stb", k), 128'(s_stb_o), 128'(k != TIMEOUT));
            check($sformatf("to_k%0d_ack", k), 128'({c_ack_o, v_err_o}), 128'(2'b00));
            tick();
        end
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        check("to_release_gnt", 128'({gnt_o, c_err_o}), 128'({2'b10, 1'b0}));
        tick();
        @(negedge clk_i);
        check("to_idle_gnt", 128'(gnt_o), 128'(2'b00));

        // Ack at count 14 restarts the watchdog
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        for (int k = 0; k <= 2 * TIMEOUT + 1; k++) begin
            s_ack_i = (k == TIMEOUT - 1);
            @(negedge clk_i);
            check($sformatf("wd_k%0d_err", k), 128'(c_err_o), 128'(k == 2 * TIMEOUT));
            check($sformatf("wd_k%0d_ack", k), 128'(c_ack_o), 128'(k == TIMEOUT - 1));
            tick();
        end
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset during OWN_C with stb high
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        @(negedge clk_i);
        check("rst_own_c", 128'({gnt_o, s_stb_o}), 128'({2'b10, 1'b1}));
        tick();
        reset_i = 1'b1;
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk_i);
        check("rst_after", 128'({gnt_o, s_cyc_o, s_stb_o, c_ack_o, c_err_o}), 128'(6'b00_0000));
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        check("rst_regrant_c", 128'(gnt_o), 128'(2'b10));
        tick();

        // Reset clears a pending fairness flag
        set_ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        set_ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        reset_i = 1'b0;
        tick();
        @(negedge clk_i);
        check("rst_fair_cleared", 128'(gnt_o), 128'(2'b01));

        // Release with ack pending; late ack is discarded
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        s_ack_i = 1'b1;
        @(negedge clk_i);
        check("late_ack", 128'({gnt_o, v_ack_o, c_ack_o}), 128'(4'b0000));
        tick();

        // Randomized traffic against the reference model
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        m_own = 0; m_fair = 1'b0; m_unacked = 0;
        reset_i = 1'b0;
        run_random(4000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
